// File: rtl/bits_pkg.sv
// Shared types and constants for the BITS instruction cache.
// Optional statistics build: BITS_ICACHE_STATS_EN.
package bits_pkg;

    localparam int WORD_W  = 128;
    localparam int CACHE_W = 256;
    localparam int BYTES   = WORD_W / 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD_ISSUE,
        S_RD_DATA,
        S_ACK
    } state_t;

    // A count of 0 (or anything past a full word) means the whole word.
    function automatic logic [4:0] valid_bytes(input logic [4:0] n);
        return (n == 5'd0 || n > 5'd16) ? 5'd16 : n;
    endfunction

    function automatic logic [15:0] byte_mask(input logic [4:0] n);
        return ~(16'hFFFF >> valid_bytes(n));
    endfunction

endpackage

// File: rtl/bits_icache_if.sv
// Fetch handshake and consume port between the packet FSM and the cache.
// The FSM side is the master, the cache side the slave.
interface bits_icache_if;

    logic       mem_req_b;
    logic       mem_ack_b;
    logic       consume_valid;
    logic [8:0] consume_bits;

    modport master (
        output mem_req_b,
        output consume_valid,
        output consume_bits,
        input  mem_ack_b
    );

    modport slave (
        input  mem_req_b,
        input  consume_valid,
        input  consume_bits,
        output mem_ack_b
    );

endinterface

// File: rtl/bits_window_shift.sv
// Combinational next-window: consume shift first, then append merge.
// Append lands directly below the post-consume fill level.
module bits_window_shift
    import bits_pkg::*;
(
    input  logic [CACHE_W-1:0] i_window,
    input  logic [8:0]         i_fill,
    input  logic               i_consume_valid,
    input  logic [8:0]         i_consume_bits,
    input  logic               i_append_en,
    input  logic [WORD_W-1:0]  i_append_word,
    input  logic [8:0]         i_append_bits,
    output logic [CACHE_W-1:0] o_window,
    output logic [8:0]         o_fill,
    output logic               o_underflow
);

    logic [CACHE_W-1:0] w_win;
    logic [8:0]         w_fill;

    always_comb begin
        w_win       = i_window;
        w_fill      = i_fill;
        o_underflow = 1'b0;
        if (i_consume_valid) begin
            if (i_consume_bits > i_fill) begin
                w_win       = '0;
                w_fill      = '0;
                o_underflow = 1'b1;
            end else begin
                w_win  = i_window << i_consume_bits;
                w_fill = i_fill - i_consume_bits;
            end
        end
        if (i_append_en) begin
            w_win  = w_win | ({i_append_word, {WORD_W{1'b0}}} >> w_fill);
            w_fill = w_fill + i_append_bits;
        end
        o_window = w_win;
        o_fill   = w_fill;
    end

endmodule

// File: rtl/bits_icache.sv
// BITS instruction-stream cache: ROM fetch FSM feeding a 256-bit bit window.
// Define BITS_ICACHE_STATS_EN to add stat_words / stat_bits counters.
module bits_icache
    import bits_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic               clk,
    input  logic               resetB,
    bits_icache_if.slave       fsm,
    output logic [CACHE_W-1:0] instruction_cache_word,
    output logic [WORD_W-1:0]  instruction_word,
    output logic [15:0]        instruction_byte_valid,
    output logic               space_available,
    output logic               done_reading_memory,
    output logic               underflow,
    output logic               rom_ceb,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [WORD_W-1:0]  rom_rdata,
    input  logic [ADDR_W-1:0]  rom_last_addr,
`ifdef BITS_ICACHE_STATS_EN
    output logic [15:0]        stat_words,
    output logic [23:0]        stat_bits,
`endif
    input  logic [4:0]         rom_last_bytes
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_skip;
    logic [ADDR_W-1:0]  r_addr;
    logic [CACHE_W-1:0] r_window;
    logic [8:0]         r_fill;
    logic [WORD_W-1:0]  r_iw;
    logic [15:0]        r_bv;
    logic               r_done;
    logic               r_uf;

    logic               w_space;
    logic               w_last;
    logic               w_data;
    logic [15:0]        w_mask;
    logic [WORD_W-1:0]  w_wmask;
    logic [8:0]         w_bits;
    logic [CACHE_W-1:0] w_win_nxt;
    logic [8:0]         w_fill_nxt;
    logic               w_uf_ev;

    assign w_space = (r_fill <= 9'd128);
    assign w_last  = (r_addr == rom_last_addr);
    assign w_data  = (r_state == S_RD_DATA);
    assign w_mask  = w_last ? byte_mask(rom_last_bytes) : 16'hFFFF;
    assign w_bits  = w_last ? {1'b0, valid_bytes(rom_last_bytes), 3'b000}
                            : 9'd128;

    always_comb begin
        w_wmask = '0;
        for (int i = 0; i < BYTES; i++) begin
            w_wmask[i*8 +: 8] = {8{w_mask[i]}};
        end
    end

    bits_window_shift u_shift (
        .i_window        (r_window),
        .i_fill          (r_fill),
        .i_consume_valid (fsm.consume_valid),
        .i_consume_bits  (fsm.consume_bits),
        .i_append_en     (w_data),
        .i_append_word   (rom_rdata & w_wmask),
        .i_append_bits   (w_bits),
        .o_window        (w_win_nxt),
        .o_fill          (w_fill_nxt),
        .o_underflow     (w_uf_ev)
    );

    // r_skip masks the request the FSM is still releasing after an ack.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (!r_skip && !fsm.mem_req_b) begin
                    w_state_nxt = (w_space && !r_done) ? S_RD_ISSUE : S_ACK;
                end
            end
            S_RD_ISSUE: w_state_nxt = S_RD_DATA;
            S_RD_DATA:  w_state_nxt = S_ACK;
            S_ACK:      w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetB) begin
        if (!resetB) begin
            r_state  <= S_IDLE;
            r_skip   <= 1'b0;
            r_addr   <= '0;
            r_window <= '0;
            r_fill   <= '0;
            r_iw     <= '0;
            r_bv     <= '0;
            r_done   <= 1'b0;
            r_uf     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_skip   <= (r_state == S_ACK);
            r_window <= w_win_nxt;
            r_fill   <= w_fill_nxt;
            if (w_uf_ev) r_uf <= 1'b1;
            if (w_data) begin
                r_iw <= rom_rdata;
                r_bv <= w_mask;
                if (w_last) r_done <= 1'b1;
                else        r_addr <= r_addr + 1'b1;
            end
        end
    end

`ifdef BITS_ICACHE_STATS_EN
    logic [15:0] r_stat_words;
    logic [23:0] r_stat_bits;
    logic [24:0] w_bits_sum;

    assign w_bits_sum = {1'b0, r_stat_bits} + {16'd0, fsm.consume_bits};

    always_ff @(posedge clk or negedge resetB) begin
        if (!resetB) begin
            r_stat_words <= '0;
            r_stat_bits  <= '0;
        end else begin
            if (w_data && r_stat_words != 16'hFFFF)
                r_stat_words <= r_stat_words + 16'd1;
            if (fsm.consume_valid)
                r_stat_bits <= w_bits_sum[24] ? 24'hFF_FFFF
                                              : w_bits_sum[23:0];
        end
    end

    assign stat_words = r_stat_words;
    assign stat_bits  = r_stat_bits;
`endif

    assign fsm.mem_ack_b           = (r_state != S_ACK);
    assign rom_ceb                 = (r_state != S_RD_ISSUE);
    assign rom_addr                = r_addr;
    assign instruction_cache_word  = r_window;
    assign instruction_word        = r_iw;
    assign instruction_byte_valid  = r_bv;
    assign space_available         = w_space;
    assign done_reading_memory     = r_done;
    assign underflow               = r_uf;

endmodule

// File: tb/tb_bits_icache.sv
// Directed + randomized bench for bits_icache against a bit-queue model.
// The model keeps the unread stream as a queue of bits, MSB-first.
module tb_bits_icache;
    import bits_pkg::*;

    logic clk = 1'b0;
    logic resetB = 1'b0;
    always #5 clk = ~clk;

    bits_icache_if bus ();

    logic [255:0] instruction_cache_word;
    logic [127:0] instruction_word;
    logic [15:0]  instruction_byte_valid;
    logic         space_available;
    logic         done_reading_memory;
    logic         underflow;
    logic         rom_ceb;
    logic [9:0]   rom_addr;
    logic [127:0] rom_rdata;
    logic [9:0]   rom_last_addr;
    logic [4:0]   rom_last_bytes;
`ifdef BITS_ICACHE_STATS_EN
    logic [15:0]  stat_words;
    logic [23:0]  stat_bits;
`endif

    bits_icache #(.ADDR_W(10)) dut (
        .clk                    (clk),
        .resetB                 (resetB),
        .fsm                    (bus),
        .instruction_cache_word (instruction_cache_word),
        .instruction_word       (instruction_word),
        .instruction_byte_valid (instruction_byte_valid),
        .space_available        (space_available),
        .done_reading_memory    (done_reading_memory),
        .underflow              (underflow),
        .rom_ceb                (rom_ceb),
        .rom_addr               (rom_addr),
        .rom_rdata              (rom_rdata),
        .rom_last_addr          (rom_last_addr),
`ifdef BITS_ICACHE_STATS_EN
        .stat_words             (stat_words),
        .stat_bits              (stat_bits),
`endif
        .rom_last_bytes         (rom_last_bytes)
    );

    logic [127:0] rom [0:15];
    int rom_reads = 0;

    always @(posedge clk) begin
        if (!rom_ceb) begin
            rom_rdata <= rom[rom_addr[3:0]];
            rom_reads <= rom_reads + 1;
        end
    end

    bit           mq[$];
    int           m_addr;
    bit           m_done;
    bit           m_uf;
    logic [127:0] m_iw;
    logic [15:0]  m_bv;
    int           npass = 0;
    int           ntot  = 0;

    task automatic chk(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
        ntot++;
        assert (got === exp) npass++;
        else $error("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [255:0] exp_win();
        logic [255:0] w = '0;
        for (int i = 0; i < mq.size() && i < 256; i++) w[255-i] = mq[i];
        return w;
    endfunction

    task automatic m_reset();
        mq.delete();
        m_addr = 0;
        m_done = 0;
        m_uf   = 0;
        m_iw   = '0;
        m_bv   = '0;
    endtask

    task automatic m_consume(input int c);
        if (c > mq.size()) begin
            mq.delete();
            m_uf = 1;
        end else begin
            repeat (c) void'(mq.pop_front());
        end
    endtask

    task automatic m_append();
        logic [127:0] w;
        bit lst;
        int nb;
        lst = (m_addr == int'(rom_last_addr));
        nb  = 16;
        if (lst && rom_last_bytes != 0 && rom_last_bytes <= 16)
            nb = int'(rom_last_bytes);
        w = rom[m_addr[3:0]];
        for (int i = 0; i < 8 * nb; i++) mq.push_back(w[127-i]);
        m_iw = w;
        for (int b = 0; b < 16; b++) m_bv[15-b] = (b < nb);
        if (lst) m_done = 1;
        else     m_addr++;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".win"},   instruction_cache_word, exp_win());
        chk({tag, ".space"}, space_available, mq.size() <= 128);
        chk({tag, ".done"},  done_reading_memory, m_done);
        chk({tag, ".uf"},    underflow, m_uf);
        chk({tag, ".iw"},    instruction_word, m_iw);
        chk({tag, ".bv"},    instruction_byte_valid, m_bv);
        chk({tag, ".ack"},   bus.mem_ack_b, 1'b1);
        chk({tag, ".addr"},  rom_addr, m_addr[9:0]);
    endtask

    task automatic do_reset(input string tag);
        resetB           = 1'b0;
        bus.mem_req_b    = 1'b1;
        bus.consume_valid = 1'b0;
        m_reset();
        #1;
        check_all(tag);
        chk({tag, ".ceb"}, rom_ceb, 1'b1);
        @(posedge clk); #1;
        resetB = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic consume(input int c, input string tag);
        bus.consume_valid = 1'b1;
        bus.consume_bits  = 9'(c);
        @(posedge clk); #1;
        bus.consume_valid = 1'b0;
        m_consume(c);
        check_all(tag);
    endtask

    task automatic fetch(input int cons, input string tag);
        bit fx;
        int r0;
        fx = (mq.size() <= 128) && !m_done;
        r0 = rom_reads;
        bus.mem_req_b = 1'b0;
        @(posedge clk); #1;
        if (fx) begin
            chk({tag, ".ack_e1"}, bus.mem_ack_b, 1'b1);
            @(posedge clk); #1;
            chk({tag, ".ack_e2"}, bus.mem_ack_b, 1'b1);
            if (cons >= 0) begin
                bus.consume_valid = 1'b1;
                bus.consume_bits  = 9'(cons);
            end
            @(posedge clk); #1;
            bus.consume_valid = 1'b0;
            if (cons >= 0) m_consume(cons);
            m_append();
        end
        chk({tag, ".ack_lo"}, bus.mem_ack_b, 1'b0);
        chk({tag, ".reads"}, 256'(rom_reads - r0), 256'(fx));
        bus.mem_req_b = 1'b1;
        @(posedge clk); #1;
        chk({tag, ".ack_pulse"}, bus.mem_ack_b, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_all(tag);
    endtask

    task automatic load_rom();
        for (int i = 0; i < 16; i++)
            rom[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    logic [255:0] old_w;
    int lim;

    initial begin
        bus.mem_req_b     = 1'b1;
        bus.consume_valid = 1'b0;
        bus.consume_bits  = '0;
        load_rom();
        rom_last_addr  = 10'd1;
        rom_last_bytes = 5'd16;
        do_reset("reset");
`ifdef BITS_ICACHE_STATS_EN
        chk("stat_words_rst", stat_words, 16'd0);
`endif

        fetch(-1, "two_w0");
        fetch(-1, "two_w1");
        fetch(-1, "two_third");
        consume(200, "two_c200");
        fetch(-1, "two_done_noread");

        do_reset("rst_d2");
        load_rom();
        rom[0][127:104] = 24'hD2FE28;
        rom_last_addr  = 10'd0;
        rom_last_bytes = 5'd3;
        fetch(-1, "d2fe");
        chk("d2fe.top", instruction_cache_word[255:232], 24'hD2FE28);
        chk("d2fe.bv", instruction_byte_valid, 16'hE000);

        do_reset("rst_fill");
        load_rom();
        rom_last_addr  = 10'd10;
        rom_last_bytes = 5'd5;
        fetch(-1, "f_w0");
        fetch(-1, "f_w1");
        consume(56, "f_c56");
        old_w = exp_win();
        consume(21, "f_c21");
        chk("f_c21.bit", instruction_cache_word[255], old_w[234]);
        chk("f_c21.nospace", space_available, 1'b0);
        fetch(-1, "f_nofetch");
        consume(79, "f_c79");
        fetch(40, "f_sim40");
        chk("f_sim40.place", instruction_cache_word[195:68], rom[2]);

        do_reset("rst_uf");
        rom_last_addr = 10'd5;
        fetch(-1, "uf_w0");
        consume(118, "uf_c118");
        consume(20, "uf_c20");
        consume(0, "uf_sticky");
        do_reset("uf_cleared");

        fetch(-1, "mr_w0");
        bus.mem_req_b = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        resetB        = 1'b0;
        bus.mem_req_b = 1'b1;
        m_reset();
        #1;
        check_all("midrst");
        @(posedge clk); #1;
        chk("midrst.noack", bus.mem_ack_b, 1'b1);
        resetB = 1'b1;
        @(posedge clk); #1;
        fetch(-1, "midrst_restart");

        do_reset("rst_rand");
        load_rom();
        rom_last_addr  = 10'($urandom_range(3, 8));
        rom_last_bytes = 5'($urandom_range(0, 16));
        for (int k = 0; k < 60; k++) begin
            lim = mq.size() + 4;
            if (lim > 256) lim = 256;
            if ($urandom_range(0, 1) == 1) begin
                if ($urandom_range(0, 2) == 0)
                    fetch(int'($urandom_range(0, lim)), "rnd_fetch_c");
                else
                    fetch(-1, "rnd_fetch");
            end else begin
                consume(int'($urandom_range(0, lim)), "rnd_cons");
            end
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
